// File: rtl/icache_pkg.sv
// Shared definitions for the direct-mapped instruction cache: geometry defaults,
// bus widths and the refill FSM state encoding.
package icache_pkg;

    localparam int unsigned ICACHE_INDEX_BITS     = 6;
    localparam int unsigned ICACHE_LINE_WORDS_LOG = 2;
    localparam int unsigned ADDR_W                = 32;
    localparam int unsigned WORD_W                = 32;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_REFILL = 1'b1
    } icache_state_e;

    // Tag width left over after index and word-offset bits of a word address
    function automatic int unsigned icache_tag_bits(input int unsigned index_bits,
                                                    input int unsigned line_words_log);
        return 30 - index_bits - line_words_log;
    endfunction

endpackage

// File: rtl/icache_if.sv
// Fetch-side and memory-side signals of the instruction cache; the cache is the
// slave, the fetcher/memory-controller environment is the master.
interface icache_if;
    import icache_pkg::*;

    logic              rdy;
    logic [ADDR_W-1:0] addr_in;
    logic              flush;
    logic              instr_valid;
    logic [WORD_W-1:0] instr_out;
    logic              mem_req_valid;
    logic [ADDR_W-1:0] mem_req_addr;
    logic              mem_resp_valid;
    logic [WORD_W-1:0] mem_resp_data;

    modport master (
        output rdy, addr_in, flush, mem_resp_valid, mem_resp_data,
        input  instr_valid, instr_out, mem_req_valid, mem_req_addr
    );

    modport slave (
        input  rdy, addr_in, flush, mem_resp_valid, mem_resp_data,
        output instr_valid, instr_out, mem_req_valid, mem_req_addr
    );

endinterface

// File: rtl/icache_data_ram.sv
// Instruction data store: one asynchronous read port for the fetch path and
// one synchronous write port for line refills.
module icache_data_ram
    import icache_pkg::*;
#(
    parameter int unsigned AW = 8,
    parameter int unsigned DW = WORD_W
) (
    input  logic          clk,
    input  logic          i_we,
    input  logic [AW-1:0] i_waddr,
    input  logic [DW-1:0] i_wdata,
    input  logic [AW-1:0] i_raddr,
    output logic [DW-1:0] o_rdata_c
);

    localparam int unsigned DEPTH = 1 << AW;

    logic [DW-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata_c = r_mem[i_raddr];

endmodule

// File: rtl/icache.sv
// Direct-mapped read-only instruction cache: combinational hit path, and a
// word-at-a-time line refill from the memory controller on a miss.
module icache
    import icache_pkg::*;
#(
    parameter int unsigned INDEX_BITS     = ICACHE_INDEX_BITS,
    parameter int unsigned LINE_WORDS_LOG = ICACHE_LINE_WORDS_LOG
) (
    input logic     clk,
    input logic     rst,
    icache_if.slave bus
);

    localparam int unsigned TAG_BITS   = icache_tag_bits(INDEX_BITS, LINE_WORDS_LOG);
    localparam int unsigned LINES      = 1 << INDEX_BITS;
    localparam int unsigned LINE_WORDS = 1 << LINE_WORDS_LOG;
    localparam int unsigned RAM_AW     = INDEX_BITS + LINE_WORDS_LOG;
    localparam int unsigned IDX_LSB    = 2 + LINE_WORDS_LOG;
    localparam int unsigned TAG_LSB    = IDX_LSB + INDEX_BITS;

    icache_state_e             r_state;
    icache_state_e             w_state_nxt;
    logic [LINES-1:0]          r_valid;
    logic [TAG_BITS-1:0]       r_tag_arr [LINES];
    logic [TAG_BITS-1:0]       r_refill_tag;
    logic [INDEX_BITS-1:0]     r_refill_index;
    logic [LINE_WORDS_LOG-1:0] r_refill_cnt;
    logic                      r_mem_req_valid;
    logic [ADDR_W-1:0]         r_mem_req_addr;

    logic [TAG_BITS-1:0]       w_tag;
    logic [INDEX_BITS-1:0]     w_index;
    logic [LINE_WORDS_LOG-1:0] w_word;
    logic                      w_unused_addr;
    logic                      w_hit;
    logic                      w_start;
    logic                      w_accept;
    logic                      w_last;
    logic [WORD_W-1:0]         w_rdata;

    assign w_tag         = bus.addr_in[ADDR_W-1:TAG_LSB];
    assign w_index       = bus.addr_in[TAG_LSB-1:IDX_LSB];
    assign w_word        = bus.addr_in[IDX_LSB-1:2];
    assign w_unused_addr = ^bus.addr_in[1:0];

    assign w_hit = r_valid[w_index] && (r_tag_arr[w_index] == w_tag);

    // Next-state and refill strobes
    always_comb begin
        w_state_nxt = r_state;
        w_start     = 1'b0;
        w_accept    = 1'b0;
        w_last      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (bus.rdy && !w_hit && !bus.flush) begin
                    w_start     = 1'b1;
                    w_state_nxt = ST_REFILL;
                end
            end
            ST_REFILL: begin
                if (bus.rdy && bus.mem_resp_valid) begin
                    w_accept = 1'b1;
                    if (r_refill_cnt == LINE_WORDS_LOG'(LINE_WORDS - 1)) begin
                        w_last      = 1'b1;
                        w_state_nxt = ST_IDLE;
                    end
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Valid bits, refill counter and request port; the line only becomes valid once complete
    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid         <= '0;
            r_refill_cnt    <= '0;
            r_mem_req_valid <= 1'b0;
            r_mem_req_addr  <= '0;
        end else if (w_start) begin
            r_valid[w_index] <= 1'b0;
            r_refill_cnt     <= '0;
            r_mem_req_valid  <= 1'b1;
            r_mem_req_addr   <= {bus.addr_in[ADDR_W-1:IDX_LSB], IDX_LSB'(0)};
        end else if (w_accept) begin
            if (w_last) begin
                r_valid[r_refill_index] <= 1'b1;
                r_refill_cnt            <= '0;
                r_mem_req_valid         <= 1'b0;
            end else begin
                r_refill_cnt   <= r_refill_cnt + LINE_WORDS_LOG'(1);
                r_mem_req_addr <= r_mem_req_addr + ADDR_W'(4);
            end
        end
    end

    // Tag store and refill target are not reset
    always_ff @(posedge clk) begin
        if (w_start) begin
            r_refill_tag   <= w_tag;
            r_refill_index <= w_index;
        end
        if (w_accept && w_last) begin
            r_tag_arr[r_refill_index] <= r_refill_tag;
        end
    end

    icache_data_ram #(
        .AW (RAM_AW),
        .DW (WORD_W)
    ) u_data_ram (
        .clk       (clk),
        .i_we      (w_accept),
        .i_waddr   ({r_refill_index, r_refill_cnt}),
        .i_wdata   (bus.mem_resp_data),
        .i_raddr   ({w_index, w_word}),
        .o_rdata_c (w_rdata)
    );

    assign bus.instr_valid   = w_hit && (r_state == ST_IDLE) && !bus.flush;
    assign bus.instr_out     = w_rdata;
    assign bus.mem_req_valid = r_mem_req_valid;
    assign bus.mem_req_addr  = r_mem_req_addr;

endmodule

// File: tb/tb_icache.sv
// Bench for icache: directed scenarios plus randomized fetch/flush/rdy/reset
// traffic, checked every cycle against a line-level model of the cache.
module tb_icache;

    logic clk = 1'b0;
    logic rst;

    icache_if bus ();

    icache dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Model: per-line valid/tag, plus the line currently being fetched
    bit          m_valid [64];
    logic [21:0] m_tag   [64];
    bit          m_busy;
    logic [31:0] m_base;
    int          m_cnt;
    logic [31:0] m_req_addr;
    int          m_ridx;
    logic [21:0] m_rtag;

    logic [31:0] req_log [$];
    logic        s_valid;
    logic [31:0] s_instr;
    logic        s_req_valid;
    logic [31:0] s_req_addr;
    bit          stray_en = 1'b0;

    // Program memory contents: 0x0,0x4,0x8,0xC hold 0x13,0x93,0x113,0x193
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a << 5) + 32'h13;
    endfunction

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h @%0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        foreach (m_valid[i]) m_valid[i] = 1'b0;
        m_busy     = 1'b0;
        m_cnt      = 0;
        m_base     = '0;
        m_req_addr = '0;
    endtask

    // One clock cycle: drive inputs, answer pending memory request, check, advance model
    task automatic step(input logic [31:0] a, input bit fl, input bit r,
                        input bit resp_ok, input bit do_rst);
        bit          hit;
        bit          exp_valid;
        bit          resp;
        int          idx;
        logic [21:0] tg;
        @(negedge clk);
        rst         = do_rst;
        bus.addr_in = a;
        bus.flush   = fl;
        bus.rdy     = r;
        resp        = 1'b0;
        bus.mem_resp_data = $urandom;
        if (bus.mem_req_valid && resp_ok) begin
            resp = 1'b1;
            bus.mem_resp_data = mem_word(bus.mem_req_addr);
        end else if (!bus.mem_req_valid && stray_en && ($urandom_range(9) == 0)) begin
            resp = 1'b1;
        end
        bus.mem_resp_valid = resp;
        #1;
        idx       = int'(a[9:4]);
        tg        = a[31:10];
        hit       = m_valid[idx] && (m_tag[idx] == tg);
        exp_valid = !m_busy && hit && !fl;
        s_valid     = bus.instr_valid;
        s_instr     = bus.instr_out;
        s_req_valid = bus.mem_req_valid;
        s_req_addr  = bus.mem_req_addr;
        check_val("instr_valid", 32'(bus.instr_valid), 32'(exp_valid));
        if (exp_valid)
            check_val("instr_out", bus.instr_out, mem_word({a[31:2], 2'b00}));
        check_val("mem_req_valid", 32'(bus.mem_req_valid), 32'(m_busy));
        check_val("mem_req_addr", bus.mem_req_addr, m_req_addr);
        @(posedge clk);
        if (do_rst) begin
            model_reset();
        end else if (r) begin
            if (!m_busy) begin
                if (!hit && !fl) begin
                    m_busy       = 1'b1;
                    m_base       = {a[31:4], 4'b0000};
                    m_cnt        = 0;
                    m_req_addr   = m_base;
                    m_ridx       = idx;
                    m_rtag       = tg;
                    m_valid[idx] = 1'b0;
                end
            end else if (resp) begin
                req_log.push_back(m_req_addr);
                if (m_cnt == 3) begin
                    m_busy          = 1'b0;
                    m_valid[m_ridx] = 1'b1;
                    m_tag[m_ridx]   = m_rtag;
                end else begin
                    m_cnt      = m_cnt + 1;
                    m_req_addr = m_base + 32'(4 * m_cnt);
                end
            end
        end
    endtask

    // Fetch a until the model says the refill it triggers is complete (bounded)
    task automatic fill(input logic [31:0] a);
        req_log.delete();
        step(a, 1'b0, 1'b1, 1'b1, 1'b0);
        for (int k = 0; k < 12 && m_busy; k++) step(a, 1'b0, 1'b1, 1'b1, 1'b0);
    endtask

    task automatic check_reqs(input string tag, input logic [31:0] base);
        check_val({tag, "_nreq"}, 32'(req_log.size()), 32'd4);
        for (int i = 0; i < req_log.size() && i < 4; i++)
            check_val({tag, "_req"}, req_log[i], base + 32'(4 * i));
    endtask

    initial begin
        logic [31:0] a;
        logic [21:0] tag_pool [4];
        tag_pool[0] = 22'h0;
        tag_pool[1] = 22'h1;
        tag_pool[2] = 22'h2A5;
        tag_pool[3] = 22'h3FFFFF;

        rst = 1'b1;
        bus.addr_in = '0;
        bus.flush = 1'b0;
        bus.rdy = 1'b1;
        bus.mem_resp_valid = 1'b0;
        bus.mem_resp_data = '0;
        repeat (3) @(posedge clk);
        model_reset();

        // Reset state
        step(32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        check_val("rst_instr_valid", 32'(s_valid), 32'd0);
        check_val("rst_req_valid", 32'(s_req_valid), 32'd0);
        check_val("rst_req_addr", s_req_addr, 32'd0);

        // 1: cold miss at 0x0
        fill(32'h0);
        check_reqs("t1", 32'h0);
        step(32'h0, 1'b0, 1'b1, 1'b1, 1'b0);
        check_val("t1_valid", 32'(s_valid), 32'd1);
        check_val("t1_instr", s_instr, 32'h13);

        // 2: hit in same cycle
        step(32'h8, 1'b0, 1'b1, 1'b1, 1'b0);
        check_val("t2_valid", 32'(s_valid), 32'd1);
        check_val("t2_instr", s_instr, 32'h113);
        check_val("t2_req_valid", 32'(s_req_valid), 32'd0);

        // 3: conflict eviction
        fill(32'h400);
        check_reqs("t3", 32'h400);
        step(32'h404, 1'b0, 1'b1, 1'b1, 1'b0);
        check_val("t3_hit_valid", 32'(s_valid), 32'd1);
        step(32'h0, 1'b0, 1'b0, 1'b1, 1'b0);
        check_val("t3_refetch_miss", 32'(s_valid), 32'd0);
        fill(32'h0);
        check_reqs("t3b", 32'h0);

        // 4: flush during refill, address moves away
        fill(32'h400);
        step(32'h0, 1'b0, 1'b1, 1'b1, 1'b0);
        step(32'h0, 1'b0, 1'b1, 1'b1, 1'b0);
        step(32'h40, 1'b1, 1'b1, 1'b1, 1'b0);
        for (int k = 0; k < 12 && m_busy; k++) step(32'h40, 1'b0, 1'b1, 1'b1, 1'b0);
        step(32'h40, 1'b0, 1'b1, 1'b1, 1'b0);
        check_val("t4_idle_req_valid", 32'(s_req_valid), 32'd0);
        step(32'h40, 1'b0, 1'b1, 1'b1, 1'b0);
        check_val("t4_refill_req_valid", 32'(s_req_valid), 32'd1);
        check_val("t4_refill_req_addr", s_req_addr, 32'h40);
        for (int k = 0; k < 12 && m_busy; k++) step(32'h40, 1'b0, 1'b1, 1'b1, 1'b0);
        step(32'h0, 1'b0, 1'b1, 1'b1, 1'b0);
        check_val("t4_line0_valid", 32'(s_valid), 32'd1);
        check_val("t4_line0_instr", s_instr, 32'h13);

        // 5: rdy low mid-refill with a response presented
        step(32'h80, 1'b0, 1'b1, 1'b1, 1'b0);
        step(32'h80, 1'b0, 1'b1, 1'b1, 1'b0);
        for (int k = 0; k < 5; k++) begin
            step(32'h80, 1'b0, 1'b0, 1'b1, 1'b0);
            check_val("t5_hold_addr", s_req_addr, 32'h84);
        end
        for (int k = 0; k < 12 && m_busy; k++) step(32'h80, 1'b0, 1'b1, 1'b1, 1'b0);
        step(32'h88, 1'b0, 1'b1, 1'b1, 1'b0);
        check_val("t5_instr", s_instr, 32'h1113);

        // 6: reset mid-refill, then full refill restarts
        step(32'hC0, 1'b0, 1'b1, 1'b1, 1'b0);
        step(32'hC0, 1'b0, 1'b1, 1'b1, 1'b0);
        step(32'hC0, 1'b0, 1'b1, 1'b1, 1'b0);
        step(32'hC0, 1'b0, 1'b1, 1'b0, 1'b1);
        step(32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        check_val("t6_req_valid", 32'(s_req_valid), 32'd0);
        check_val("t6_req_addr", s_req_addr, 32'd0);
        check_val("t6_line0_cleared", 32'(s_valid), 32'd0);
        fill(32'h0);
        check_reqs("t6", 32'h0);

        // Randomized traffic over a small address pool to mix hits, misses and conflicts
        stray_en = 1'b1;
        a = 32'h0;
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(9) < 3)
                a = {tag_pool[$urandom_range(3)], 6'($urandom_range(7)),
                     2'($urandom_range(3)), 2'($urandom_range(3))};
            step(a, $urandom_range(9) == 0, $urandom_range(99) < 85,
                 $urandom_range(99) < 80, $urandom_range(199) == 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
